// File: rtl/is_pkg.sv
// is_pkg: shared issue-stage constants (ready-vector bit positions, default
// multiplier latency) and the ALU1 branch / address-adder state encodings.
package is_pkg;

    localparam int FUN_MULT_BIT = 0;
    localparam int FUN_ADD1_BIT = 1;
    localparam int FUN_ADD2_BIT = 2;
    localparam int FUN_ADDR_BIT = 3;

    localparam int MULT_LAT_DEF = 4;
    localparam int CNT_W_DEF    = 3;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_PEND = 1'b1
    } br_state_t;

    typedef enum logic {
        ADR_IDLE = 1'b0,
        ADR_WAIT = 1'b1
    } adr_state_t;

endpackage

// File: rtl/fu_mul_busy_cnt.sv
// fu_mul_busy_cnt: multiplier occupancy counter. Loads LAT-1 on an accepted
// issue and counts down to zero; busy while nonzero.
module fu_mul_busy_cnt #(
    parameter int LAT = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    output logic [W-1:0] cnt,
    output logic         busy
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: reload on issue, otherwise decrement until empty.
    always_comb begin
        cnt_d = load ? W'(LAT - 1) : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/fu_rdy_ctl.sv
// fu_rdy_ctl: issue-stage function-unit ready vector. The ready vector is built
// only from registered state plus pipe_stall/mem_busy so there is no path from
// the issue valids back into the priority decoder.
// Build option FU_MULT_PIPE_EN: treat the multiplier as fully pipelined
// (no occupancy counter, mul_cnt held at 0).
module fu_rdy_ctl
    import is_pkg::*;
#(
    parameter int MULT_LAT     = MULT_LAT_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FUN_MULT_BIT = is_pkg::FUN_MULT_BIT,
    parameter int FUN_ADD1_BIT = is_pkg::FUN_ADD1_BIT,
    parameter int FUN_ADD2_BIT = is_pkg::FUN_ADD2_BIT,
    parameter int FUN_ADDR_BIT = is_pkg::FUN_ADDR_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_iss_vld,
    input  logic             alu1_iss_vld,
    input  logic             alu1_iss_br,
    input  logic             alu2_iss_vld,
    input  logic             adr_iss_vld,
    input  logic             br_res_vld,
    input  logic             flush,
    input  logic             mem_busy,
    input  logic             mem_done,
    input  logic             pipe_stall,
    output logic [3:0]       fun_rdy_frm_exe,
    output logic [CNT_W-1:0] mul_cnt,
    output logic             br_pend,
    output logic             iss_err
);

    logic       init_done_q, init_done_d;
    br_state_t  br_q, br_d;
    adr_state_t adr_q, adr_d;
    logic       iss_err_q, iss_err_d;
    logic       base_rdy, mul_rdy, alu1_rdy, alu2_rdy, adr_rdy;
    logic       mul_busy;
    logic [3:0] rdy_vec;

`ifdef FU_MULT_PIPE_EN
    assign mul_busy = 1'b0;
    assign mul_cnt  = '0;
`else
    logic mul_go;

    // Only an accepted issue occupies the multiplier.
    assign mul_go = mul_iss_vld & mul_rdy;

    fu_mul_busy_cnt #(
        .LAT (MULT_LAT),
        .W   (CNT_W)
    ) u_mul_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_go),
        .cnt   (mul_cnt),
        .busy  (mul_busy)
    );
`endif

    // Per-unit ready from registered state; a global stall masks everything.
    always_comb begin
        base_rdy = init_done_q & ~pipe_stall;
        mul_rdy  = base_rdy & ~mul_busy;
        alu1_rdy = base_rdy & (br_q == BR_IDLE);
        alu2_rdy = base_rdy;
        adr_rdy  = base_rdy & (adr_q == ADR_IDLE) & ~mem_busy;
        rdy_vec  = '0;
        rdy_vec[FUN_MULT_BIT] = mul_rdy;
        rdy_vec[FUN_ADD1_BIT] = alu1_rdy;
        rdy_vec[FUN_ADD2_BIT] = alu2_rdy;
        rdy_vec[FUN_ADDR_BIT] = adr_rdy;
    end

    // Next state for init, branch FSM, address FSM and the sticky error;
    // issues against a not-ready unit are flagged but never change state.
    always_comb begin
        init_done_d = 1'b1;
        br_d        = br_q;
        adr_d       = adr_q;
        if (br_q == BR_PEND) begin
            if (br_res_vld | flush) br_d = BR_IDLE;
        end else if (alu1_iss_vld & alu1_iss_br & alu1_rdy) begin
            br_d = BR_PEND;
        end
        if (adr_q == ADR_WAIT) begin
            if (mem_done) adr_d = ADR_IDLE;
        end else if (adr_iss_vld & adr_rdy & ~mem_done) begin
            adr_d = ADR_WAIT;
        end
        iss_err_d = iss_err_q
                  | (mul_iss_vld  & ~mul_rdy)
                  | (alu1_iss_vld & ~alu1_rdy)
                  | (alu2_iss_vld & ~alu2_rdy)
                  | (adr_iss_vld  & ~adr_rdy)
                  | (br_res_vld & (br_q == BR_IDLE) & ~flush);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            br_q        <= BR_IDLE;
            adr_q       <= ADR_IDLE;
            iss_err_q   <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
            br_q        <= br_d;
            adr_q       <= adr_d;
            iss_err_q   <= iss_err_d;
        end
    end

    assign fun_rdy_frm_exe = rdy_vec;
    assign br_pend         = (br_q == BR_PEND);
    assign iss_err         = iss_err_q;

endmodule

// File: tb/tb_fu_rdy_ctl.sv
// tb_fu_rdy_ctl: table-driven directed vectors, hand-written corner sequences
// and randomized traffic checked against a timestamp-based occupancy model.
module tb_fu_rdy_ctl;

`ifdef FU_MULT_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif
    localparam int MULT_LAT = 4;

    typedef struct packed {
        logic mv, a1v, a1b, a2v, adv, brres, flush, busy, done, stall;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [3:0] rdy;
        logic [2:0] cnt;
        logic       bp;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mul_iss_vld = 0, alu1_iss_vld = 0, alu1_iss_br = 0, alu2_iss_vld = 0;
    logic       adr_iss_vld = 0, br_res_vld = 0, flush = 0, mem_busy = 0, mem_done = 0, pipe_stall = 0;
    logic [3:0] fun_rdy_frm_exe;
    logic [2:0] mul_cnt;
    logic       br_pend, iss_err;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: multiplier free-at timestamp, pending flags, sticky error.
    int now = 0;
    int mul_free = 0;
    bit m_init = 0, m_brp = 0, m_adrw = 0, m_err = 0;

    fu_rdy_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .mul_iss_vld(mul_iss_vld), .alu1_iss_vld(alu1_iss_vld), .alu1_iss_br(alu1_iss_br),
        .alu2_iss_vld(alu2_iss_vld), .adr_iss_vld(adr_iss_vld), .br_res_vld(br_res_vld),
        .flush(flush), .mem_busy(mem_busy), .mem_done(mem_done), .pipe_stall(pipe_stall),
        .fun_rdy_frm_exe(fun_rdy_frm_exe), .mul_cnt(mul_cnt), .br_pend(br_pend), .iss_err(iss_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_rdy(input in_t v);
        logic       b;
        logic [3:0] r;
        b    = m_init && !v.stall;
        r    = '0;
        r[0] = b && (PIPE || now >= mul_free);
        r[1] = b && !m_brp;
        r[2] = b;
        r[3] = b && !m_adrw && !v.busy;
        return r;
    endfunction

    function automatic int m_cnt();
        return (!PIPE && mul_free > now) ? mul_free - now : 0;
    endfunction

    task automatic m_update(input in_t v);
        logic [3:0] r;
        r = m_rdy(v);
        m_err = m_err || (v.mv && !r[0]) || (v.a1v && !r[1]) || (v.a2v && !r[2])
              || (v.adv && !r[3]) || (v.brres && !m_brp && !v.flush);
        if (!PIPE && v.mv && r[0]) mul_free = now + MULT_LAT;
        if (m_brp) begin
            if (v.brres || v.flush) m_brp = 0;
        end else if (v.a1v && v.a1b && r[1]) m_brp = 1;
        if (m_adrw) begin
            if (v.done) m_adrw = 0;
        end else if (v.adv && r[3] && !v.done) m_adrw = 1;
        m_init = 1;
        now++;
    endtask

    task automatic drive(input in_t v);
        mul_iss_vld = v.mv; alu1_iss_vld = v.a1v; alu1_iss_br = v.a1b; alu2_iss_vld = v.a2v;
        adr_iss_vld = v.adv; br_res_vld = v.brres; flush = v.flush; mem_busy = v.busy;
        mem_done = v.done; pipe_stall = v.stall;
    endtask

    // One cycle: drive at negedge, compare against the model, then advance it.
    task automatic cyc(input in_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk("model_rdy", fun_rdy_frm_exe, m_rdy(v));
        chk("model_cnt", mul_cnt, m_cnt());
        chk("model_br_pend", br_pend, m_brp);
        chk("model_iss_err", iss_err, m_err);
        m_update(v);
    endtask

    // Asynchronous reset between clock edges, then release and the ready-low cycle.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive('0);
        #1;
        chk("rst_async_cnt", mul_cnt, 0);
        chk("rst_async_br_pend", br_pend, 0);
        chk("rst_async_err", iss_err, 0);
        chk("rst_async_rdy", fun_rdy_frm_exe, 0);
        now = 0; mul_free = 0; m_init = 0; m_brp = 0; m_adrw = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_rdy", fun_rdy_frm_exe, 4'b0000);
        m_update('0);
    endtask

    vec_t tab[29];

    initial begin
        tab = '{
            '{10'b0000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b1000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1110, 3'd3, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1110, 3'd2, 1'b0, 1'b0},
            '{10'b0000000001, 4'b0000, 3'd1, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0110000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1101, 3'd0, 1'b1, 1'b0},
            '{10'b0000010000, 4'b1101, 3'd0, 1'b1, 1'b0},
            '{10'b0100000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0001000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0110000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000001000, 4'b1101, 3'd0, 1'b1, 1'b0},
            '{10'b0000100000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000001000, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000010, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000100, 4'b0111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000010, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000100010, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b1000000000, 4'b1111, 3'd0, 1'b0, 1'b0},
            '{10'b1000000000, 4'b1110, 3'd3, 1'b0, 1'b0},
            '{10'b0000000000, 4'b1110, 3'd2, 1'b0, 1'b1},
            '{10'b0000010000, 4'b1110, 3'd1, 1'b0, 1'b1},
            '{10'b0000000000, 4'b1111, 3'd0, 1'b0, 1'b1}
        };

        do_reset();
        foreach (tab[i]) begin
            logic [3:0] e_rdy;
            cyc(tab[i].in);
            e_rdy = PIPE ? {tab[i].rdy[3:1], tab[i].rdy[2]} : tab[i].rdy;
            chk($sformatf("tab%0d_rdy", i), fun_rdy_frm_exe, e_rdy);
            chk($sformatf("tab%0d_cnt", i), mul_cnt, PIPE ? 3'd0 : tab[i].cnt);
            chk($sformatf("tab%0d_br_pend", i), br_pend, tab[i].bp);
            chk($sformatf("tab%0d_err", i), iss_err, PIPE ? 1'b0 : tab[i].err);
        end

        // Branch resolve with flush in BR_IDLE is benign; without flush it is an error.
        do_reset();
        cyc(10'b0000011000);
        cyc(10'b0000000000);
        chk("br_res_flush_idle_err", iss_err, 1'b0);
        cyc(10'b0000010000);
        cyc(10'b0000000000);
        chk("br_res_idle_err", iss_err, 1'b1);

        // Occupy every unit, then reset asynchronously mid-countdown.
        do_reset();
        cyc(10'b1110100000);
        cyc(10'b0000000000);
        chk("busy_all_cnt", mul_cnt, PIPE ? 3'd0 : 3'd3);
        chk("busy_all_br_pend", br_pend, 1'b1);
        chk("busy_all_rdy", fun_rdy_frm_exe, PIPE ? 4'b0101 : 4'b0100);
        do_reset();
        cyc(10'b0000000000);
        chk("post_rst_rdy", fun_rdy_frm_exe, 4'b1111);

        // Randomized traffic, issuing mostly to ready units.
        for (int n = 0; n < 1500; n++) begin
            in_t        v;
            logic [3:0] r;
            bit         wild;
            if (n % 250 == 249) do_reset();
            v       = '0;
            v.stall = ($urandom_range(7) == 0);
            v.busy  = ($urandom_range(3) == 0);
            r       = m_rdy(v);
            wild    = ($urandom_range(60) == 0);
            v.mv    = ($urandom_range(3) == 0) && (r[0] || wild);
            v.a1v   = ($urandom_range(2) == 0) && (r[1] || wild);
            v.a1b   = $urandom_range(1);
            v.a2v   = ($urandom_range(2) == 0) && (r[2] || wild);
            v.adv   = ($urandom_range(3) == 0) && (r[3] || wild);
            v.brres = ($urandom_range(5) == 0) && (m_brp || wild);
            v.flush = ($urandom_range(15) == 0);
            v.done  = ($urandom_range(3) == 0);
            cyc(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
